gpio_pwm_engine: RTL and testbench



---
 rtl/gpio_pwm_engine.sv | 160 ++++++++++++++++
 tb/tb_gpio_pwm_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pwm_engine.sv
// GPIO output engine with a power-of-two prescaler, a shared-period PWM stage
// and a per-pin mux that selects either a static GPIO value or a PWM channel.
// Optional macro PWM_READBACK_EN adds a registered register/counter read port.
module gpio_pwm_engine #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned COUNTER_WIDTH   = 16,
  parameter int unsigned PRESCALER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [2:0]               wr_addr,
  input  logic [COUNTER_WIDTH-1:0] wr_data,
`ifdef PWM_READBACK_EN
  input  logic [2:0]               rd_addr,
  output logic [COUNTER_WIDTH-1:0] rd_data,
`endif
  output logic [CHANNELS-1:0]      pwm_o,
  output logic [CHANNELS-1:0]      gpio_o,
  output logic                     tick_o
);

  localparam int unsigned DivWidth = 1 << PRESCALER_WIDTH;

  // Programmed registers
  logic [CHANNELS-1:0]                     gpio_out_q, gpio_out_d;
  logic [CHANNELS-1:0]                     func_sel_q, func_sel_d;
  logic [PRESCALER_WIDTH-1:0]              sel_q, sel_d;
  logic [COUNTER_WIDTH-1:0]                period_q, period_d;
  logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]  duty_q, duty_d;

  // Active (shadowed) copies, reloaded only at period wrap
  logic [COUNTER_WIDTH-1:0]                period_act_q, period_act_d;
  logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]  duty_act_q, duty_act_d;

  // Prescaler and PWM state
  logic [DivWidth-1:0]                     div_q, div_d;
  logic [DivWidth-1:0]                     tick_mask;
  logic                                    tick_q, tick_d;
  logic [COUNTER_WIDTH-1:0]                cnt_q, cnt_d;
  logic [CHANNELS-1:0]                     pwm_q, pwm_d;

  // Register write decode
  always_comb begin
    gpio_out_d = gpio_out_q;
    func_sel_d = func_sel_q;
    sel_d      = sel_q;
    period_d   = period_q;
    duty_d     = duty_q;
    if (wr_en) begin
      unique case (wr_addr)
        3'd0:    gpio_out_d = wr_data[CHANNELS-1:0];
        3'd1:    func_sel_d = wr_data[CHANNELS-1:0];
        3'd2:    sel_d      = wr_data[PRESCALER_WIDTH-1:0];
        3'd3:    period_d   = wr_data;
        default: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (wr_addr == 3'(4 + c)) duty_d[c] = wr_data;
          end
        end
      endcase
    end
  end

  // Free-running divider; tick when the low sel bits are all ones
  always_comb begin
    div_d     = div_q + DivWidth'(1);
    tick_mask = (DivWidth'(1) << sel_q) - DivWidth'(1);
    tick_d    = ((div_q & tick_mask) == tick_mask);
  end

  // PWM counter advance and shadow reload at wrap
  always_comb begin
    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    if (tick_q) begin
      if (cnt_q >= period_act_q) begin
        cnt_d        = '0;
        period_act_d = period_q;
        duty_act_d   = duty_q;
      end else begin
        cnt_d = cnt_q + COUNTER_WIDTH'(1);
      end
    end
  end

  // Per-channel compare
  always_comb begin
    pwm_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pwm_d[c] = (cnt_q < duty_act_q[c]);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out_q   <= '0;
      func_sel_q   <= '0;
      sel_q        <= '0;
      period_q     <= '0;
      duty_q       <= '0;
      period_act_q <= '0;
      duty_act_q   <= '0;
      div_q        <= '0;
      tick_q       <= 1'b0;
      cnt_q        <= '0;
      pwm_q        <= '0;
    end else begin
      gpio_out_q   <= gpio_out_d;
      func_sel_q   <= func_sel_d;
      sel_q        <= sel_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      div_q        <= div_d;
      tick_q       <= tick_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
    end
  end

`ifdef PWM_READBACK_EN
  logic [COUNTER_WIDTH-1:0] rd_data_q, rd_data_d;

  // Read mux; narrow registers are zero-extended, unmapped indices expose cnt
  always_comb begin
    rd_data_d = cnt_q;
    unique case (rd_addr)
      3'd0:    rd_data_d = COUNTER_WIDTH'(gpio_out_q);
      3'd1:    rd_data_d = COUNTER_WIDTH'(func_sel_q);
      3'd2:    rd_data_d = COUNTER_WIDTH'(sel_q);
      3'd3:    rd_data_d = period_q;
      default: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (rd_addr == 3'(4 + c)) rd_data_d = duty_q[c];
        end
      end
    endcase
  end

  // Read data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

  // Outputs
  always_comb begin
    pwm_o  = pwm_q;
    tick_o = tick_q;
    gpio_o = (func_sel_q & pwm_q) | (~func_sel_q & gpio_out_q);
  end

endmodule

// File: tb/tb_gpio_pwm_engine.sv
// Directed bench for gpio_pwm_engine: expected samples are queued per scenario
// and popped one per clock against pwm_o, gpio_o or tick_o.
module tb_gpio_pwm_engine;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic [CH-1:0] pwm_o;
  logic [CH-1:0] gpio_o;
  logic          tick_o;
`ifdef PWM_READBACK_EN
  logic [2:0]    rd_addr = '0;
  logic [CW-1:0] rd_data;
`endif

  gpio_pwm_engine #(
    .CHANNELS       (CH),
    .COUNTER_WIDTH  (CW),
    .PRESCALER_WIDTH(PW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
`ifdef PWM_READBACK_EN
    .rd_addr(rd_addr),
    .rd_data(rd_data),
`endif
    .pwm_o  (pwm_o),
    .gpio_o (gpio_o),
    .tick_o (tick_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         sig;   // 0 pwm_o, 1 gpio_o, 2 tick_o
    logic [3:0] mask;
    logic [3:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [3:0] observe(int sig);
    case (sig)
      0:       return pwm_o;
      1:       return gpio_o;
      default: return {3'b000, tick_o};
    endcase
  endfunction

  task automatic check(string tag, logic [CW-1:0] obs, logic [CW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(string tag, int sig, logic [3:0] mask, logic [3:0] exp);
    exp_t e;
    e.tag  = tag;
    e.sig  = sig;
    e.mask = mask;
    e.exp  = exp & mask;
    sb_q.push_back(e);
  endtask

  // One queued expectation per falling edge; also ends any pending write
  task automatic drain();
    exp_t e;
    logic [3:0] obs;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      wr_en = 1'b0;
      e   = sb_q.pop_front();
      obs = observe(e.sig) & e.mask;
      check(e.tag, CW'(obs), CW'(e.exp));
    end
  endtask

  task automatic wr(logic [2:0] addr, logic [CW-1:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded search for a 0->1 transition; returns at the sample showing the 1
  task automatic wait_rise(string tag, int sig, int b, int limit);
    logic [3:0] v;
    logic       prev;
    logic       cur;
    logic       found;
    found = 1'b0;
    v     = observe(sig);
    prev  = v[b];
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      v   = observe(sig);
      cur = v[b];
      if (!prev && cur) found = 1'b1;
      prev = cur;
    end
    n_checks++;
    assert (found) n_pass++;
    else $error("FAIL %s: observed no rising edge expected one within %0d clocks", tag, limit);
  endtask

  initial begin
    logic [7:0]  t1;
    logic [9:0]  t2;
    logic [7:0]  t3;
    logic [15:0] t4;

    // Reset state
    #12;
    check("rst_pwm", CW'(pwm_o), '0);
    check("rst_gpio", CW'(gpio_o), '0);
    check("rst_tick", CW'(tick_o), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // sel=0, period=3, duty0=2: gpio_o[0] repeats 1,1,0,0; upper pins static
    wr(3'd0, 16'h000A);
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'd3);
    wr(3'd4, 16'd2);
    idle(20);
    wait_rise("t1_align", 1, 0, 20);
    t1 = 8'b1001_1001;
    for (int i = 7; i >= 0; i--) push("t1_gpio", 1, 4'hF, {3'b101, t1[i]});
    drain();

    // sel=1, duty0=1: high 2 of 8 clocks, tick every second clock
    wr(3'd2, 16'd1);
    wr(3'd4, 16'd1);
    idle(30);
    wait_rise("t2_align", 0, 0, 40);
    t2 = 10'b10_0000_0110;
    for (int i = 9; i >= 0; i--) push("t2_pwm0", 0, 4'h1, {3'b000, t2[i]});
    drain();
    wait_rise("t2_tick_align", 2, 0, 8);
    for (int i = 0; i < 6; i++) push("t2_tick", 2, 4'h1, {3'b000, 1'(i % 2)});
    drain();

    // Duty boundaries: 0 -> low, > period -> high, 3 of 4 on channel 3
    wr(3'd2, 16'd0);
    wr(3'd4, 16'd0);
    wr(3'd5, 16'd5);
    wr(3'd6, 16'd4);
    wr(3'd7, 16'd3);
    idle(20);
    wait_rise("t3_align", 0, 3, 20);
    t3 = 8'b1101_1101;
    for (int i = 7; i >= 0; i--) push("t3_pwm", 0, 4'hF, {t3[i], 3'b110});
    drain();

    // Duty change mid-period only takes effect after the next wrap
    wr(3'd3, 16'd7);
    wr(3'd4, 16'd4);
    idle(30);
    wait_rise("t4_align", 0, 0, 30);
    wr_en   = 1'b1;
    wr_addr = 3'd4;
    wr_data = 16'd1;
    t4 = 16'b1110_0001_0000_0001;
    for (int i = 15; i >= 0; i--) push("t4_pwm0", 0, 4'h1, {3'b000, t4[i]});
    drain();

    // Mid-period reset clears everything asynchronously
    wr(3'd0, 16'h000F);
    wr(3'd1, 16'h0001);
    wait_rise("t5_align", 0, 0, 20);
    check("t5_pre_gpio", CW'(gpio_o), 16'h000F);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_pwm", CW'(pwm_o), '0);
    check("t5_rst_gpio", CW'(gpio_o), '0);
    check("t5_rst_tick", CW'(tick_o), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) push("t5_post_gpio", 1, 4'hF, 4'h0);
    drain();
    wr(3'd1, 16'h000F);
    for (int i = 0; i < 6; i++) push("t5_post_pwm_sel", 1, 4'hF, 4'h0);
    drain();
    // period left at 0 by reset, duty0=2 -> constant high
    wr(3'd4, 16'd2);
    idle(4);
    for (int i = 0; i < 6; i++) push("t5_period0", 0, 4'hF, 4'h1);
    drain();

`ifdef PWM_READBACK_EN
    wr(3'd3, 16'h1234);
    rd_addr = 3'd3;
    @(negedge clk);
    check("rb_period", rd_data, 16'h1234);
    rd_addr = 3'd1;
    @(negedge clk);
    check("rb_func_sel", rd_data, 16'h000F);
    rd_addr = 3'd4;
    @(negedge clk);
    check("rb_duty0", rd_data, 16'h0002);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
